poly_note_player: RTL
=====================

// Module: poly_note_player
// PURPOSE
//  Parametrised multi-voice successor to the single-voice note player. Holds NUM_VOICES
//  independent notes, each with its own duration counter and phase accumulator. On each
//  codec request it produces one mixed 16-bit sample. It sits between the song reader/
//  chord sequencer (note loads, 1/48 s beat) and the codec interface.
// PARAMETERS
//  NUM_VOICES   4   simultaneous voices, power of 2, range 2..8; VIDX_W = $clog2(NUM_VOICES)
//  DUR_WIDTH    6   width of each duration counter, in beats
//  PHASE_WIDTH  22  phase accumulator width; sine address = phase[PHASE_WIDTH-1 -: 10]
// PORTS
//  clk               in   1           system clock
//  reset_n           in   1           asynchronous, active-low reset
//  play_enable       in   1           1 = run (phases and durations advance); 0 = freeze and mute
//  load_new_note     in   1           load request; taken only while load_ready = 1
//  load_voice        in   VIDX_W      target voice for the load
//  note_to_load      in   6           note index; 0 = rest
//  duration_to_load  in   DUR_WIDTH   note length in beats
//  load_ready        out  1           1 = load FSM idle and able to accept a load
//  beat              in   1           1-cycle pulse at 48 Hz
//  generate_next_sample in 1          1-cycle codec sample request
//  sample_out        out  16          signed mixed sample, held until the next result
//  new_sample_ready  out  1           1-cycle pulse when sample_out is updated
//  voice_done        out  NUM_VOICES  bit i = 1 when duration counter i is 0
// BEHAVIOUR
//  Reset: all counters, phases, steps and notes = 0. voice_done = all 1s, load_ready = 1,
//   sample_out = 0, new_sample_ready = 0. Both FSMs return to IDLE. An in-flight load or
//   sample is discarded with no pulse.
//  Load FSM L_IDLE->L_ROM->L_WRITE->L_IDLE:
//   - load_ready = (state == L_IDLE).
//   - On the accept cycle, latch voice, note and duration.
//   - L_ROM: frequency_rom addr = latched note (1-cycle registered read).
//   - L_WRITE: step[v] = rom dout (20b), note[v], dur[v] = duration, phase[v] = 0.
//   - Requests while not ready are dropped, not queued. voice_done[v] updates the cycle after L_WRITE.
//  Duration: on beat & play_enable, every dur[i] != 0 decrements by 1 and saturates at 0.
//   - If L_WRITE targets voice i in the same cycle, the write wins (no decrement).
//   - A load with duration 0 leaves the voice immediately done and silent.
//  Active voice: dur[i] != 0 && note[i] != 0.
//  Mix FSM M_IDLE -> {M_ADDR, M_ACC} x NUM_VOICES -> M_OUT -> M_IDLE:
//   - Leave M_IDLE on generate_next_sample; requests while busy are ignored.
//   - M_ADDR v: if active and play_enable, phase[v] += step[v] (wraps modulo
//     2^PHASE_WIDTH). Drive sine_rom addr from the updated phase.
//   - M_ACC v: acc += (active && play_enable) ? sine_dout : 0, sign-extended.
//     acc is (16 + VIDX_W) bits signed and is cleared on leaving M_IDLE.
//   - M_OUT: register sample_out and pulse new_sample_ready for 1 cycle.
//   - Latency: request-to-pulse = 2*NUM_VOICES + 1 cycles; 9 for the default.
//  play_enable = 0: phases and durations frozen. Loads still accepted. Samples are still
//   produced on request, with value 0.
// CONFIGURATION
//  MIX_SATURATE_EN undefined: sample_out = acc >>> VIDX_W (average; cannot overflow).
//  MIX_SATURATE_EN defined: no shift. acc is clamped to [-32768, 32767] for louder
//   chords; sample_out = clamp(acc).
// TESTING
//  1 Reset: reset_n low mid-sample -> all outputs at reset values; no new_sample_ready
//    pulse; load_ready = 1.
//  2 Load v2, note 5, duration 3; 3 beats with play_enable = 1 -> voice_done[2] falls
//    3 cycles after accept and rises on the 3rd beat. A second load during L_ROM is dropped.
//  3 Single voice active, generate_next_sample -> new_sample_ready exactly 9 cycles later;
//    phase advanced by exactly one step.
//  4 Beat coincident with L_WRITE to the same voice -> counter = loaded value. A note 0
//    load -> voice muted but counter still runs.
//  5 Force four voices to sine +20000 -> sample_out = 20000 without MIX_SATURATE_EN,
//    32767 with it.
//  6 play_enable = 0 while voices are active -> sample_out = 0 each request; counters and
//    phases unchanged.

Source files
------------

// File: rtl/poly_note_player.sv
// rtl/poly_note_player.sv - multi-voice note player mixing NUM_VOICES sine voices per codec request
//
// Holds NUM_VOICES independent notes (duration counter, phase accumulator, step).
// A load FSM writes one voice at a time through a registered frequency ROM. A mix FSM
// walks every voice on each codec request: it advances the phase, reads a registered
// sine ROM and accumulates one mixed 16-bit sample.
//
// Build option: MIX_SATURATE_EN
//   undefined : sample_out = acc >>> VIDX_W (average of the voices, cannot overflow)
//   defined   : sample_out = acc clamped to [-32768, 32767] (louder chords)
//
// Ports:
//   clk                  system clock
//   reset_n              asynchronous active-low reset
//   play_enable          1 = phases and durations advance; 0 = frozen, samples muted
//   load_new_note        load request, taken only while load_ready = 1
//   load_voice           target voice of the load
//   note_to_load         note index, 0 = rest
//   duration_to_load     note length in beats
//   load_ready           load FSM idle and able to accept a load
//   beat                 1-cycle pulse at 48 Hz
//   generate_next_sample 1-cycle codec sample request
//   sample_out           signed mixed sample, held until the next result
//   new_sample_ready     1-cycle pulse when sample_out is updated
//   voice_done           bit i = 1 when duration counter i is 0

module poly_note_player #(
   parameter int NUM_VOICES  = 4,
   parameter int DUR_WIDTH   = 6,
   parameter int PHASE_WIDTH = 22
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          play_enable,
   input  logic                          load_new_note,
   input  logic [$clog2(NUM_VOICES)-1:0] load_voice,
   input  logic [5:0]                    note_to_load,
   input  logic [DUR_WIDTH-1:0]          duration_to_load,
   output logic                          load_ready,
   input  logic                          beat,
   input  logic                          generate_next_sample,
   output logic signed [15:0]            sample_out,
   output logic                          new_sample_ready,
   output logic [NUM_VOICES-1:0]         voice_done
);

   localparam int VIDX_W = $clog2(NUM_VOICES);
   localparam int ACC_W  = 16 + VIDX_W;

   typedef enum logic [1:0] {L_IDLE, L_ROM, L_WRITE} load_state_t;
   typedef enum logic [1:0] {M_IDLE, M_ADDR, M_ACC, M_OUT} mix_state_t;

   load_state_t load_state;
   mix_state_t  mix_state;

   logic [VIDX_W-1:0]    lat_voice;
   logic [5:0]           lat_note;
   logic [DUR_WIDTH-1:0] lat_dur;
   logic [VIDX_W-1:0]    mix_voice;

   logic [19:0]              freq_dout;
   logic signed [15:0]       sine_dout;
   logic signed [ACC_W-1:0]  acc;

   logic [DUR_WIDTH-1:0]   dur   [NUM_VOICES];
   logic [5:0]             note  [NUM_VOICES];
   logic [19:0]            step  [NUM_VOICES];
   logic [PHASE_WIDTH-1:0] phase [NUM_VOICES];

   logic [NUM_VOICES-1:0]   active;
   logic                    mix_gate;
   logic [PHASE_WIDTH-1:0]  phase_next;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [15:0]      mix_result;

   // Phase step per note: twelve semitone steps for the lowest octave (note 1 = 55 Hz at
   // a 48 kHz sample rate and 22-bit phase), doubled for each octave above it.
   function automatic logic [19:0] freq_lookup(input logic [5:0] n);
      logic [5:0]  idx;
      logic [2:0]  oct;
      logic [3:0]  semi;
      logic [19:0] base;
      idx  = n - 6'd1;
      oct  = 3'(idx / 6'd12);
      semi = 4'(idx % 6'd12);
      case (semi)
         4'd0:    base = 20'd4806;
         4'd1:    base = 20'd5092;
         4'd2:    base = 20'd5394;
         4'd3:    base = 20'd5715;
         4'd4:    base = 20'd6055;
         4'd5:    base = 20'd6415;
         4'd6:    base = 20'd6797;
         4'd7:    base = 20'd7201;
         4'd8:    base = 20'd7629;
         4'd9:    base = 20'd8083;
         4'd10:   base = 20'd8563;
         default: base = 20'd9072;
      endcase
      return (n == 6'd0) ? 20'd0 : (base << oct);
   endfunction

   // Parabolic sine: each half period is x*(512-x)/2 over x = 0..511, negated for the
   // second half. The single peak value 32768 is clipped to 32767.
   function automatic logic signed [15:0] sine_lookup(input logic [9:0] a);
      logic [17:0] x;
      logic [17:0] prod;
      logic [15:0] mag;
      x    = {9'd0, a[8:0]};
      prod = x * (18'd512 - x);
      mag  = (prod > 18'd65535) ? 16'h7fff : 16'(prod >> 1);
      return a[9] ? -$signed(mag) : $signed(mag);
   endfunction

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_flags
      assign active[gi]     = (dur[gi] != '0) && (note[gi] != '0);
      assign voice_done[gi] = (dur[gi] == '0);
   end

   assign mix_gate   = active[mix_voice] && play_enable;
   assign phase_next = phase[mix_voice] + (mix_gate ? PHASE_WIDTH'(step[mix_voice]) : '0);
   assign acc_next   = acc + (mix_gate ? $signed({{VIDX_W{sine_dout[15]}}, sine_dout}) : '0);

`ifdef MIX_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   always_comb begin
      mix_result = acc_next[15:0];
      if (acc_next > SAT_MAX) begin
         mix_result = 16'h7fff;
      end else if (acc_next < SAT_MIN) begin
         mix_result = 16'h8000;
      end
   end
`else
   // acc is exactly 16 + VIDX_W bits, so its top 16 bits are acc >>> VIDX_W.
   always_comb begin
      mix_result = acc_next[ACC_W-1 -: 16];
   end
`endif

   // Registered ROM reads: frequency addressed by the latched note (valid in L_WRITE),
   // sine addressed by the freshly updated phase (valid in M_ACC).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         freq_dout <= '0;
         sine_dout <= '0;
      end else begin
         freq_dout <= freq_lookup(lat_note);
         sine_dout <= sine_lookup(phase_next[PHASE_WIDTH-1 -: 10]);
      end
   end

   // Load FSM: load_ready is registered and equal to (load_state == L_IDLE).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_state <= L_IDLE;
         load_ready <= 1'b1;
         lat_voice  <= '0;
         lat_note   <= '0;
         lat_dur    <= '0;
      end else begin
         case (load_state)
            L_IDLE: begin
               if (load_new_note) begin
                  lat_voice  <= load_voice;
                  lat_note   <= note_to_load;
                  lat_dur    <= duration_to_load;
                  load_state <= L_ROM;
                  load_ready <= 1'b0;
               end
            end
            L_ROM: begin
               load_state <= L_WRITE;
            end
            L_WRITE: begin
               load_state <= L_IDLE;
               load_ready <= 1'b1;
            end
            default: begin
               load_state <= L_IDLE;
               load_ready <= 1'b1;
            end
         endcase
      end
   end

   // Voice state. A load write to a voice overrides both the beat decrement and a
   // concurrent phase update by the mixer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            dur[i]   <= '0;
            note[i]  <= '0;
            step[i]  <= '0;
            phase[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (load_state == L_WRITE && lat_voice == VIDX_W'(i)) begin
               dur[i]   <= lat_dur;
               note[i]  <= lat_note;
               step[i]  <= freq_dout;
               phase[i] <= '0;
            end else begin
               if (beat && play_enable && dur[i] != '0) begin
                  dur[i] <= dur[i] - DUR_WIDTH'(1);
               end
               if (mix_state == M_ADDR && mix_voice == VIDX_W'(i)) begin
                  phase[i] <= phase_next;
               end
            end
         end
      end
   end

   // Mix FSM: one M_ADDR/M_ACC pair per voice. The result is registered on the last
   // M_ACC edge so the pulse is high during M_OUT, 2*NUM_VOICES+1 cycles after request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mix_state        <= M_IDLE;
         mix_voice        <= '0;
         acc              <= '0;
         sample_out       <= '0;
         new_sample_ready <= 1'b0;
      end else begin
         case (mix_state)
            M_IDLE: begin
               if (generate_next_sample) begin
                  acc       <= '0;
                  mix_voice <= '0;
                  mix_state <= M_ADDR;
               end
            end
            M_ADDR: begin
               mix_state <= M_ACC;
            end
            M_ACC: begin
               acc <= acc_next;
               if (mix_voice == VIDX_W'(NUM_VOICES - 1)) begin
                  sample_out       <= mix_result;
                  new_sample_ready <= 1'b1;
                  mix_state        <= M_OUT;
               end else begin
                  mix_voice <= mix_voice + VIDX_W'(1);
                  mix_state <= M_ADDR;
               end
            end
            M_OUT: begin
               new_sample_ready <= 1'b0;
               mix_state        <= M_IDLE;
            end
            default: begin
               new_sample_ready <= 1'b0;
               mix_state        <= M_IDLE;
            end
         endcase
      end
   end

endmodule
